// File: rtl/control_unit.sv
// control_unit: multi-cycle RV32I control FSM (FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP).
// Optional feature: define RETIRE_COUNTER_EN to build the 32-bit retired-instruction counter on instret.
module control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic        instr_valid,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_sel_data,
    output logic        ir_load,
    output logic        pc_load,
    output logic [1:0]  pc_sel,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    // RV32I major opcodes, matching the RISCV_* constants of arch_defines.v.
    localparam logic [6:0] RISCV_OP_LUI      = 7'b0110111;
    localparam logic [6:0] RISCV_OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] RISCV_OP_JAL      = 7'b1101111;
    localparam logic [6:0] RISCV_OP_JALR     = 7'b1100111;
    localparam logic [6:0] RISCV_OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] RISCV_OP_LOAD     = 7'b0000011;
    localparam logic [6:0] RISCV_OP_STORE    = 7'b0100011;
    localparam logic [6:0] RISCV_OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] RISCV_OP_OP       = 7'b0110011;
    localparam logic [6:0] RISCV_OP_MEM_MISC = 7'b0001111;
    localparam logic [6:0] RISCV_OP_SYSTEM   = 7'b1110011;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SEL_IMM   = 2'b01;
    localparam logic [1:0] PC_SEL_ALU   = 2'b10;

    localparam logic [1:0] WB_SEL_ALU   = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD  = 2'b01;
    localparam logic [1:0] WB_SEL_PC4   = 2'b10;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   illegal_q;
    logic   retire;

    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_nop_class;

    assign is_load      = (opcode == RISCV_OP_LOAD);
    assign is_store     = (opcode == RISCV_OP_STORE);
    assign is_branch    = (opcode == RISCV_OP_BRANCH);
    assign is_jal       = (opcode == RISCV_OP_JAL);
    assign is_jalr      = (opcode == RISCV_OP_JALR);
    assign is_nop_class = (opcode == RISCV_OP_MEM_MISC) || (opcode == RISCV_OP_SYSTEM);

    // func3 belongs to the decoder interface but no control decision here depends on it;
    // the remaining opcodes are listed for reference and all take the WRITEBACK path.
    logic unused_inputs;
    assign unused_inputs = ^{func3, RISCV_OP_LUI, RISCV_OP_AUIPC, RISCV_OP_OP_IMM, RISCV_OP_OP};

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Strobes are gated by reset itself so they drop immediately, even mid-wait.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel_data = 1'b0;
        ir_load      = 1'b0;
        pc_load      = 1'b0;
        pc_sel       = PC_SEL_PLUS4;
        reg_write    = 1'b0;
        wb_sel       = WB_SEL_ALU;
        retire       = 1'b0;

        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_load = 1'b1;
                        state_d = DECODE;
                    end
                end

                DECODE: begin
                    state_d = instr_valid ? EXECUTE : TRAP;
                end

                EXECUTE: begin
                    if (is_branch) begin
                        pc_load = 1'b1;
                        pc_sel  = branch_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else if (is_nop_class) begin
                        pc_load = 1'b1;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else if (is_load || is_store) begin
                        state_d = MEM;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end

                MEM: begin
                    mem_req      = 1'b1;
                    mem_sel_data = 1'b1;
                    mem_we       = is_store;
                    if (mem_ready) begin
                        if (is_store) begin
                            pc_load = 1'b1;
                            retire  = 1'b1;
                            state_d = FETCH;
                        end else begin
                            state_d = WRITEBACK;
                        end
                    end
                end

                WRITEBACK: begin
                    reg_write = 1'b1;
                    pc_load   = 1'b1;
                    retire    = 1'b1;
                    state_d   = FETCH;
                    if (is_load) begin
                        wb_sel = WB_SEL_LOAD;
                    end else if (is_jal || is_jalr) begin
                        wb_sel = WB_SEL_PC4;
                    end
                    if (is_jal) begin
                        pc_sel = PC_SEL_IMM;
                    end else if (is_jalr) begin
                        pc_sel = PC_SEL_ALU;
                    end
                end

                TRAP: begin
                    state_d = TRAP;
                end

                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    assign state   = state_q;
    assign illegal = illegal_q;

`ifdef RETIRE_COUNTER_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign instret       = '0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed self-checking bench for control_unit; follows RETIRE_COUNTER_EN
// so instret expectations match the build.
module tb_control_unit;

`ifdef RETIRE_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_MEM_MISC = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [2:0] S_F = 3'd0;
    localparam logic [2:0] S_D = 3'd1;
    localparam logic [2:0] S_E = 3'd2;
    localparam logic [2:0] S_M = 3'd3;
    localparam logic [2:0] S_W = 3'd4;
    localparam logic [2:0] S_T = 3'd5;

    // Packed strobes: {mem_req, mem_we, mem_sel_data, ir_load, pc_load, pc_sel[1:0], reg_write, wb_sel[1:0]}
    localparam logic [9:0] C_IDLE       = 10'b0000000000;
    localparam logic [9:0] C_FETCH_RDY  = 10'b1001000000;
    localparam logic [9:0] C_FETCH_WAIT = 10'b1000000000;
    localparam logic [9:0] C_MEM_RD     = 10'b1010000000;
    localparam logic [9:0] C_MEM_WR     = 10'b1110000000;
    localparam logic [9:0] C_MEM_WR_RDY = 10'b1110100000;
    localparam logic [9:0] C_WB_ALU     = 10'b0000100100;
    localparam logic [9:0] C_WB_LOAD    = 10'b0000100101;
    localparam logic [9:0] C_WB_JAL     = 10'b0000101110;
    localparam logic [9:0] C_WB_JALR    = 10'b0000110110;
    localparam logic [9:0] C_PC_IMM     = 10'b0000101000;
    localparam logic [9:0] C_PC_PLUS4   = 10'b0000100000;

    logic        clk;
    logic        reset;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        instr_valid;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        mem_sel_data;
    logic        ir_load;
    logic        pc_load;
    logic [1:0]  pc_sel;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] instret;

    logic [9:0]  ctl_vec;
    assign ctl_vec = {mem_req, mem_we, mem_sel_data, ir_load, pc_load, pc_sel, reg_write, wb_sel};

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_ret  = '0;

    control_unit dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .func3        (func3),
        .instr_valid  (instr_valid),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_sel_data (mem_sel_data),
        .ir_load      (ir_load),
        .pc_load      (pc_load),
        .pc_sel       (pc_sel),
        .reg_write    (reg_write),
        .wb_sel       (wb_sel),
        .illegal      (illegal),
        .state        (state),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Check one cycle's state and strobes, then advance to the next falling edge.
    task automatic cyc(input string tag, input logic [2:0] es, input logic [9:0] ec);
        #1;
        check({tag, "_state"}, {29'd0, state}, {29'd0, es});
        check({tag, "_ctl"}, {22'd0, ctl_vec}, {22'd0, ec});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic retired(input string tag);
        exp_ret = exp_ret + 32'd1;
        #1;
        check({tag, "_next_state"}, {29'd0, state}, {29'd0, S_F});
        check({tag, "_instret"}, instret, CNT_EN ? exp_ret : 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        opcode       = OP_OP_IMM;
        func3        = 3'd0;
        instr_valid  = 1'b1;
        branch_taken = 1'b0;
        mem_ready    = 1'b1;

        @(negedge clk);
        #1;
        check("rst_state", {29'd0, state}, {29'd0, S_F});
        check("rst_ctl", {22'd0, ctl_vec}, {22'd0, C_IDLE});
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_instret", instret, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADDI, zero wait states: 0,1,2,4 then back to 0.
        cyc("addi_f", S_F, C_FETCH_RDY);
        cyc("addi_d", S_D, C_IDLE);
        cyc("addi_e", S_E, C_IDLE);
        cyc("addi_wb", S_W, C_WB_ALU);
        retired("addi");

        // LW with two wait cycles in MEM: 7 cycles in total.
        opcode = OP_LOAD;
        cyc("lw_f", S_F, C_FETCH_RDY);
        cyc("lw_d", S_D, C_IDLE);
        cyc("lw_e", S_E, C_IDLE);
        mem_ready = 1'b0;
        cyc("lw_m0", S_M, C_MEM_RD);
        cyc("lw_m1", S_M, C_MEM_RD);
        mem_ready = 1'b1;
        cyc("lw_m2", S_M, C_MEM_RD);
        cyc("lw_wb", S_W, C_WB_LOAD);
        retired("lw");

        // SW with one FETCH wait and one MEM wait; write strobe steady through the wait.
        opcode    = OP_STORE;
        mem_ready = 1'b0;
        cyc("sw_fw", S_F, C_FETCH_WAIT);
        mem_ready = 1'b1;
        cyc("sw_f", S_F, C_FETCH_RDY);
        cyc("sw_d", S_D, C_IDLE);
        cyc("sw_e", S_E, C_IDLE);
        mem_ready = 1'b0;
        cyc("sw_mw", S_M, C_MEM_WR);
        mem_ready = 1'b1;
        cyc("sw_m", S_M, C_MEM_WR_RDY);
        retired("sw");

        // BEQ taken, then not taken.
        opcode       = OP_BRANCH;
        branch_taken = 1'b1;
        cyc("beq_t_f", S_F, C_FETCH_RDY);
        cyc("beq_t_d", S_D, C_IDLE);
        cyc("beq_t_e", S_E, C_PC_IMM);
        retired("beq_t");
        branch_taken = 1'b0;
        cyc("beq_n_f", S_F, C_FETCH_RDY);
        cyc("beq_n_d", S_D, C_IDLE);
        cyc("beq_n_e", S_E, C_PC_PLUS4);
        retired("beq_n");

        // JAL / JALR writeback selects, SYSTEM as a 3-cycle no-op.
        opcode = OP_JAL;
        cyc("jal_f", S_F, C_FETCH_RDY);
        cyc("jal_d", S_D, C_IDLE);
        cyc("jal_e", S_E, C_IDLE);
        cyc("jal_wb", S_W, C_WB_JAL);
        retired("jal");
        opcode = OP_JALR;
        cyc("jalr_f", S_F, C_FETCH_RDY);
        cyc("jalr_d", S_D, C_IDLE);
        cyc("jalr_e", S_E, C_IDLE);
        cyc("jalr_wb", S_W, C_WB_JALR);
        retired("jalr");
        opcode = OP_SYSTEM;
        cyc("sys_f", S_F, C_FETCH_RDY);
        cyc("sys_d", S_D, C_IDLE);
        cyc("sys_e", S_E, C_PC_PLUS4);
        retired("sys");

        // Illegal instruction: TRAP is terminal with every strobe low.
        opcode = OP_OP;
        cyc("ill_f", S_F, C_FETCH_RDY);
        instr_valid = 1'b0;
        cyc("ill_d", S_D, C_IDLE);
        instr_valid = 1'b1;
        #1;
        check("ill_flag", {31'd0, illegal}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc("trap_hold", S_T, C_IDLE);
        end
        check("trap_instret", instret, CNT_EN ? exp_ret : 32'd0);
        reset = 1'b1;
        #1;
        exp_ret = '0;
        check("trap_rst_state", {29'd0, state}, {29'd0, S_F});
        check("trap_rst_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of a FETCH wait drops mem_req with no clock edge.
        mem_ready = 1'b0;
        cyc("fw0", S_F, C_FETCH_WAIT);
        #1;
        check("fw_req_before", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        #1;
        check("fw_req_async_drop", {31'd0, mem_req}, 32'd0);
        check("fw_rst_instret", instret, 32'd0);
        mem_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        // First edge after reset starts a fresh fetch.
        opcode = OP_OP_IMM;
        cyc("post_f", S_F, C_FETCH_RDY);
        cyc("post_d", S_D, C_IDLE);
        cyc("post_e", S_E, C_IDLE);
        cyc("post_wb", S_W, C_WB_ALU);
        retired("post");

`ifdef RETIRE_COUNTER_EN
        // Counter wraps from all-ones to zero on a FENCE retire.
        opcode = OP_MEM_MISC;
        force dut.instret_q = 32'hFFFF_FFFF;
        cyc("wrap_f", S_F, C_FETCH_RDY);
        cyc("wrap_d", S_D, C_IDLE);
        release dut.instret_q;
        #1;
        check("wrap_preload", instret, 32'hFFFF_FFFF);
        cyc("wrap_e", S_E, C_PC_PLUS4);
        #1;
        check("wrap_instret", instret, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have a port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have a port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 The block SHALL have a port opcode, input, 7 bits: instruction[6:0] from the decoder, driven from the instruction register (IR).
REQ-004 The block SHALL have a port func3, input, 3 bits: instruction[14:12] from the decoder.
REQ-005 The block SHALL have a port instr_valid, input, 1 bit: decoder legality flag.
REQ-006 The block SHALL have a port branch_taken, input, 1 bit: branch comparator result, valid in EXECUTE.
REQ-007 The block SHALL have a port mem_ready, input, 1 bit: memory completes the access in the cycle it is high.
REQ-008 The block SHALL have a port mem_req, output, 1 bit: memory access request.
REQ-009 The block SHALL have a port mem_we, output, 1 bit: write strobe, qualified by mem_req.
REQ-010 The block SHALL have a port mem_sel_data, output, 1 bit: 0 = address from PC, 1 = address from ALU.
REQ-011 The block SHALL have a port ir_load, output, 1 bit: IR captures memory read data.
REQ-012 The block SHALL have a port pc_load, output, 1 bit: PC update enable.
REQ-013 The block SHALL have a port pc_sel, output, 2 bits: 00 = PC+4, 01 = PC+imm, 10 = ALU result with bit 0 cleared.
REQ-014 The block SHALL have a port reg_write, output, 1 bit: register-file write enable.
REQ-015 The block SHALL have a port wb_sel, output, 2 bits: 00 = ALU, 01 = load data, 10 = PC+4.
REQ-016 The block SHALL have a port illegal, output, 1 bit: sticky illegal-instruction flag.
REQ-017 The block SHALL have a port state, output, 3 bits: current FSM state, for debug.
REQ-018 The block SHALL have a port instret, output, 32 bits: count of retired instructions.

Function
REQ-019 The FSM SHALL have exactly these states and encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5; the encodings 6 and 7 SHALL go to FETCH.
REQ-020 Opcode and func3 values SHALL be the RISCV_* constants in arch_defines.v.
REQ-021 In FETCH, the block SHALL drive mem_req=1, mem_we=0 and mem_sel_data=0.
- When mem_ready=1, ir_load SHALL be 1 in that same cycle and the next state SHALL be DECODE.
- When mem_ready=0, the state SHALL remain FETCH.
REQ-022 In DECODE, the next state SHALL be TRAP if instr_valid=0, else EXECUTE; DECODE SHALL have no side effects.
REQ-023 In EXECUTE, the next state and outputs SHALL depend on opcode as follows.
- BRANCH: pc_load=1, pc_sel=01 if branch_taken else 00, next state FETCH, instruction retires.
- MEM_MISC or SYSTEM: pc_load=1, pc_sel=00, next state FETCH, instruction retires (no-op).
- LOAD or STORE: next state MEM.
- All other opcodes: next state WRITEBACK.
REQ-024 In MEM, the block SHALL drive mem_req=1, mem_sel_data=1, and mem_we=1 only for STORE; the state SHALL hold while mem_ready=0.
- STORE with mem_ready=1: pc_load=1, pc_sel=00, instruction retires, next state FETCH.
- LOAD with mem_ready=1: next state WRITEBACK.
REQ-025 In WRITEBACK, the block SHALL drive reg_write=1 and pc_load=1, then go to FETCH; the instruction retires.
- wb_sel SHALL be 01 for LOAD, 10 for JAL/JALR, and 00 otherwise.
- pc_sel SHALL be 01 for JAL, 10 for JALR, and 00 otherwise.
REQ-026 Entering TRAP SHALL set illegal=1; TRAP SHALL be terminal until reset, with all strobes held at 0.
REQ-027 All strobes SHALL be combinational from state, opcode, func3, branch_taken and mem_ready; any output not listed for a state SHALL be 0.
REQ-028 Latency with zero wait states SHALL be: OP/OP_IMM/LUI/AUIPC/JAL/JALR 4 cycles, LOAD 5, STORE 4, BRANCH/FENCE/SYSTEM 3; each mem_ready=0 cycle SHALL add 1 cycle.
REQ-029 mem_req SHALL stay high without gaps until mem_ready is sampled high, and mem_we SHALL stay stable during that wait.

Reset
REQ-030 While reset=1, the block SHALL drive state=FETCH, illegal=0, instret=0, and every strobe SHALL be 0 (including mem_req); this SHALL hold even in the middle of a memory wait.
REQ-031 After reset deasserts, the first rising clock edge SHALL begin a FETCH; an access interrupted by reset SHALL be discarded without a retire.

Configuration
REQ-032 With RETIRE_COUNTER_EN defined, instret SHALL increment by 1 on each retire edge and wrap from 0xFFFFFFFF to 0.
REQ-033 With RETIRE_COUNTER_EN undefined, instret SHALL be constant 0 and no counter flops SHALL exist.

Verification
REQ-034 The bench SHALL run an ADDI with mem_ready tied to 1: states 0,1,2,4, then 0; reg_write=1 and wb_sel=00 in cycle 4; instret=1.
REQ-035 The bench SHALL run an LW with 2 wait cycles in MEM: mem_req and mem_sel_data held high for 3 cycles, then WRITEBACK with wb_sel=01; total 7 cycles.
REQ-036 The bench SHALL run a BEQ with branch_taken=1, then again with branch_taken=0: pc_sel=01 and then 00 in EXECUTE, with pc_load=1 in both cases and no reg_write.
REQ-037 The bench SHALL drive instr_valid=0 in DECODE: illegal=1 and state=5, with no further mem_req for 10 cycles; reset then returns state=0 and illegal=0.
REQ-038 The bench SHALL assert reset during a FETCH wait: mem_req falls without waiting for a clock edge, and instret is unchanged (0).
REQ-039 The bench SHALL, with RETIRE_COUNTER_EN defined, preload instret to 0xFFFFFFFF and retire one NOP: instret=0.
